// File: rtl/registers_wr_arbiter.sv
`default_nettype none
// =============================================================================
// registers_wr_arbiter: write-port arbiter, load-return FIFO and read hazard /
// read pipeline control for the shared per-thread register file.
// Revision: 1.0
// =============================================================================
module registers_wr_arbiter #(
  parameter int WIDTH         = 16,
  parameter int N_THREADS     = 6,
  parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1,
  parameter int FIFO_DEPTH    = 4,
  parameter int HIGH_WATER    = 3
) (
  input  logic                           CLK,
  input  logic                           rst_n,
  input  logic                           mem_wr_valid,
  input  logic [WIDTH-1:0]               mem_wr_data,
  input  logic [3:0]                     mem_wr_addr,
  input  logic [N_THREADS_MSB:0]         mem_wr_thread,
  output logic                           mem_almost_full,
  output logic                           mem_overflow,
  input  logic [2:0]                     eu_valid,
  output logic [2:0]                     eu_ready,
  input  logic [11:0]                    eu_addr,
  input  logic [3*(N_THREADS_MSB+1)-1:0] eu_thread,
  input  logic                           rd_req,
  input  logic [3:0]                     rd_addr_in,
  input  logic [N_THREADS_MSB:0]         rd_thread_in,
  output logic                           rd_ready,
  output logic                           rd_valid,
  output logic [WIDTH-1:0]               mem_din,
  output logic [1:0]                     reg_din_select,
  output logic                           mem_wr_en,
  output logic                           wr_en,
  output logic [3:0]                     wr_addr,
  output logic [N_THREADS_MSB:0]         wr_thread_num,
  output logic [3:0]                     rd_addr,
  output logic [N_THREADS_MSB:0]         rd_thread_num,
  output logic                           rd_en0,
  output logic                           rd_en1
);
  localparam int TW = N_THREADS_MSB + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] HW_CNT   = CW'(HIGH_WATER);

  logic [WIDTH-1:0] fifo_data   [FIFO_DEPTH];
  logic [3:0]       fifo_addr   [FIFO_DEPTH];
  logic [TW-1:0]    fifo_thread [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, offset;
  logic [CW-1:0]    count;
  logic [1:0]       rr_ptr, grant_idx, cand;
  logic [3:0]       req;
  logic             grant_any, pop, push, push_ok, hazard;

  // Requester 0 is the FIFO head; 1..3 are the execution units.
  assign req = {eu_valid, (count != '0)};

  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    cand      = 2'd0;
    if (rst_n) begin
      if (count >= HW_CNT) begin
        grant_any = 1'b1;
      end else begin
        for (int k = 0; k < 4; k++) begin
          cand = rr_ptr + 2'(k);
          if (!grant_any && req[cand]) begin
            grant_any = 1'b1;
            grant_idx = cand;
          end
        end
      end
    end
  end

  assign pop            = grant_any && (grant_idx == 2'd0);
  assign mem_wr_en      = pop;
  assign wr_en          = grant_any && (grant_idx != 2'd0);
  assign reg_din_select = grant_any ? grant_idx : 2'd0;
  assign mem_din        = fifo_data[rd_ptr];

  always_comb begin
    wr_addr       = fifo_addr[rd_ptr];
    wr_thread_num = fifo_thread[rd_ptr];
    eu_ready      = 3'b000;
    for (int i = 0; i < 3; i++) begin
      if (wr_en && (grant_idx == 2'(i + 1))) begin
        eu_ready[i]   = 1'b1;
        wr_addr       = eu_addr[4*i +: 4];
        wr_thread_num = eu_thread[TW*i +: TW];
      end
    end
  end

  // A read must not overtake any write still queued or being performed.
  always_comb begin
    hazard = 1'b0;
    offset = '0;
    if ((mem_wr_en || wr_en) && (wr_addr == rd_addr_in) && (wr_thread_num == rd_thread_in))
      hazard = 1'b1;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      offset = PW'(i) - rd_ptr;
      if ((CW'(offset) < count) && (fifo_addr[i] == rd_addr_in) && (fifo_thread[i] == rd_thread_in))
        hazard = 1'b1;
    end
    for (int i = 0; i < 3; i++) begin
      if (eu_valid[i] && (eu_addr[4*i +: 4] == rd_addr_in) && (eu_thread[TW*i +: TW] == rd_thread_in))
        hazard = 1'b1;
    end
  end

  assign rd_ready        = rst_n && rd_req && !hazard;
  assign rd_en0          = rd_req && rd_ready;
  assign rd_addr         = rd_addr_in;
  assign rd_thread_num   = rd_thread_in;
  assign mem_almost_full = (count >= AF_CNT);

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push    = rst_n && mem_wr_valid;
  assign push_ok = push && ((count != FULL_CNT) || pop);

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rr_ptr       <= 2'd0;
      mem_overflow <= 1'b0;
      rd_en1       <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (pop && !push_ok) count <= count - 1'b1;
      if (push && !push_ok) mem_overflow <= 1'b1;
      if (grant_any)        rr_ptr       <= grant_idx + 2'd1;
      rd_en1   <= rd_en0;
      rd_valid <= rd_en1;
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      fifo_data[wr_ptr]   <= mem_wr_data;
      fifo_addr[wr_ptr]   <= mem_wr_addr;
      fifo_thread[wr_ptr] <= mem_wr_thread;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_registers_wr_arbiter.sv
`default_nettype none
// =============================================================================
// tb_registers_wr_arbiter: directed self-checking bench for registers_wr_arbiter.
// Revision: 1.0
// =============================================================================
module tb_registers_wr_arbiter;
  logic        CLK, rst_n;
  logic        mem_wr_valid;
  logic [15:0] mem_wr_data;
  logic [3:0]  mem_wr_addr;
  logic [2:0]  mem_wr_thread;
  logic [2:0]  eu_valid;
  logic [11:0] eu_addr;
  logic [8:0]  eu_thread;
  logic        rd_req;
  logic [3:0]  rd_addr_in;
  logic [2:0]  rd_thread_in;

  logic        mem_almost_full, mem_overflow, rd_ready, rd_valid, mem_wr_en, wr_en, rd_en0, rd_en1;
  logic [2:0]  eu_ready, wr_thread_num, rd_thread_num;
  logic [15:0] mem_din;
  logic [1:0]  reg_din_select;
  logic [3:0]  wr_addr, rd_addr;

  logic        b_mem_almost_full, b_mem_overflow, b_rd_ready, b_rd_valid, b_mem_wr_en, b_wr_en, b_rd_en0, b_rd_en1;
  logic [2:0]  b_eu_ready, b_wr_thread_num, b_rd_thread_num;
  logic [15:0] b_mem_din;
  logic [1:0]  b_reg_din_select;
  logic [3:0]  b_wr_addr, b_rd_addr;

  int tests = 0;
  int fails = 0;
  logic [15:0] drain_exp [4];

  registers_wr_arbiter dut (
    .CLK(CLK), .rst_n(rst_n),
    .mem_wr_valid(mem_wr_valid), .mem_wr_data(mem_wr_data), .mem_wr_addr(mem_wr_addr),
    .mem_wr_thread(mem_wr_thread), .mem_almost_full(mem_almost_full), .mem_overflow(mem_overflow),
    .eu_valid(eu_valid), .eu_ready(eu_ready), .eu_addr(eu_addr), .eu_thread(eu_thread),
    .rd_req(rd_req), .rd_addr_in(rd_addr_in), .rd_thread_in(rd_thread_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .mem_din(mem_din), .reg_din_select(reg_din_select),
    .mem_wr_en(mem_wr_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_thread_num(wr_thread_num),
    .rd_addr(rd_addr), .rd_thread_num(rd_thread_num), .rd_en0(rd_en0), .rd_en1(rd_en1)
  );

  // Second instance with the high-water override out of reach.
  registers_wr_arbiter #(.HIGH_WATER(5)) dut_b (
    .CLK(CLK), .rst_n(rst_n),
    .mem_wr_valid(mem_wr_valid), .mem_wr_data(mem_wr_data), .mem_wr_addr(mem_wr_addr),
    .mem_wr_thread(mem_wr_thread), .mem_almost_full(b_mem_almost_full), .mem_overflow(b_mem_overflow),
    .eu_valid(eu_valid), .eu_ready(b_eu_ready), .eu_addr(eu_addr), .eu_thread(eu_thread),
    .rd_req(rd_req), .rd_addr_in(rd_addr_in), .rd_thread_in(rd_thread_in),
    .rd_ready(b_rd_ready), .rd_valid(b_rd_valid), .mem_din(b_mem_din), .reg_din_select(b_reg_din_select),
    .mem_wr_en(b_mem_wr_en), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_thread_num(b_wr_thread_num),
    .rd_addr(b_rd_addr), .rd_thread_num(b_rd_thread_num), .rd_en0(b_rd_en0), .rd_en1(b_rd_en1)
  );

  // Register file with two-stage registered read, fed by the first instance.
  logic [15:0] rf [128];
  logic [15:0] rf_q1, dout;
  always @(posedge CLK) begin
    if (mem_wr_en) rf[{wr_thread_num, wr_addr}] <= mem_din;
    if (rd_en0)    rf_q1 <= rf[{rd_thread_num, rd_addr}];
    if (rd_en1)    dout  <= rf_q1;
  end

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic mv, input logic [15:0] md, input logic [3:0] ma, input logic [2:0] mt,
                       input logic [2:0] ev, input logic rq, input logic [3:0] ra, input logic [2:0] rt);
    mem_wr_valid  = mv;
    mem_wr_data   = md;
    mem_wr_addr   = ma;
    mem_wr_thread = mt;
    eu_valid      = ev;
    rd_req        = rq;
    rd_addr_in    = ra;
    rd_thread_in  = rt;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 4'd0, 3'd0, 3'b000, 1'b0, 4'd0, 3'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    eu_addr   = 12'h321;
    eu_thread = 9'b011_010_001;
    drain_exp[0] = 16'hC003; drain_exp[1] = 16'hC004;
    drain_exp[2] = 16'hC005; drain_exp[3] = 16'hC008;
    idle();

    // Reset with every requester active
    cyc(); drive(1'b1, 16'h1111, 4'd0, 3'd0, 3'b111, 1'b1, 4'd0, 3'd0);
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_mem_wr_en", 32'(mem_wr_en), 0);
    check("rst_eu_ready", 32'(eu_ready), 0);
    check("rst_rd_ready", 32'(rd_ready), 0);
    cyc(); rst_n = 1'b1; idle();
    check("rst_almost_full", 32'(mem_almost_full), 0);
    check("rst_overflow", 32'(mem_overflow), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_fifo_empty", 32'(mem_wr_en), 0);

    // Round robin: one grant to EU1 moves the pointer to EU2
    cyc(); drive(1'b0, 16'h0, 4'd0, 3'd0, 3'b001, 1'b0, 4'd0, 3'd0);
    check("rr0_eu_ready", 32'(eu_ready), 'b001);
    check("rr0_sel", 32'(reg_din_select), 1);
    check("rr0_wr_addr", 32'(wr_addr), 1);
    cyc(); drive(1'b0, 16'h0, 4'd0, 3'd0, 3'b111, 1'b0, 4'd0, 3'd0);
    check("rr1_eu_ready", 32'(eu_ready), 'b010);
    check("rr1_sel", 32'(reg_din_select), 2);
    check("rr1_wr_en", 32'(wr_en), 1);
    check("rr1_wr_thread", 32'(wr_thread_num), 2);
    cyc();
    check("rr2_eu_ready", 32'(eu_ready), 'b100);
    check("rr2_sel", 32'(reg_din_select), 3);
    check("rr2_wr_addr", 32'(wr_addr), 3);
    cyc();
    check("rr3_eu_ready", 32'(eu_ready), 'b001);
    check("rr3_sel", 32'(reg_din_select), 1);
    check("rr3_mem_wr_en", 32'(mem_wr_en), 0);
    cyc(); drive(1'b0, 16'h0, 4'd0, 3'd0, 3'b100, 1'b0, 4'd0, 3'd0);
    check("rr4_eu_ready", 32'(eu_ready), 'b100);

    // High-water priority
    cyc(); drive(1'b1, 16'hA001, 4'd4, 3'd2, 3'b111, 1'b0, 4'd0, 3'd0);
    check("hw1_eu_ready", 32'(eu_ready), 'b001);
    check("hw1_almost_full", 32'(mem_almost_full), 0);
    cyc(); drive(1'b1, 16'hA002, 4'd5, 3'd3, 3'b111, 1'b0, 4'd0, 3'd0);
    check("hw2_eu_ready", 32'(eu_ready), 'b010);
    cyc(); drive(1'b1, 16'hA003, 4'd6, 3'd4, 3'b111, 1'b0, 4'd0, 3'd0);
    check("hw3_eu_ready", 32'(eu_ready), 'b100);
    check("hw3_almost_full", 32'(mem_almost_full), 0);
    cyc(); drive(1'b0, 16'h0, 4'd0, 3'd0, 3'b111, 1'b0, 4'd0, 3'd0);
    check("hw4_almost_full", 32'(mem_almost_full), 1);
    check("hw4_mem_wr_en", 32'(mem_wr_en), 1);
    check("hw4_wr_en", 32'(wr_en), 0);
    check("hw4_eu_ready", 32'(eu_ready), 0);
    check("hw4_sel", 32'(reg_din_select), 0);
    check("hw4_mem_din", 32'(mem_din), 'hA001);
    check("hw4_wr_addr", 32'(wr_addr), 4);
    check("hw4_wr_thread", 32'(wr_thread_num), 2);
    cyc();
    check("hw5_almost_full", 32'(mem_almost_full), 0);
    check("hw5_eu_ready", 32'(eu_ready), 'b001);
    cyc(); idle();
    check("hw6_mem_wr_en", 32'(mem_wr_en), 1);
    check("hw6_mem_din", 32'(mem_din), 'hA002);
    check("hw6_wr_addr", 32'(wr_addr), 5);
    cyc();
    check("hw7_mem_din", 32'(mem_din), 'hA003);
    check("hw7_wr_thread", 32'(wr_thread_num), 4);
    cyc();
    check("hw8_mem_wr_en", 32'(mem_wr_en), 0);
    check("hw8_wr_en", 32'(wr_en), 0);

    // Read blocked by a queued load to the same register
    cyc(); drive(1'b1, 16'hBEEF, 4'd7, 3'd2, 3'b001, 1'b0, 4'd0, 3'd0);
    check("hz0_eu_ready", 32'(eu_ready), 'b001);
    cyc(); drive(1'b0, 16'h0, 4'd0, 3'd0, 3'b010, 1'b1, 4'd7, 3'd2);
    check("hz1_eu_ready", 32'(eu_ready), 'b010);
    check("hz1_rd_ready", 32'(rd_ready), 0);
    check("hz1_rd_en0", 32'(rd_en0), 0);
    cyc(); drive(1'b0, 16'h0, 4'd0, 3'd0, 3'b000, 1'b1, 4'd7, 3'd2);
    check("hz2_mem_wr_en", 32'(mem_wr_en), 1);
    check("hz2_mem_din", 32'(mem_din), 'hBEEF);
    check("hz2_rd_ready", 32'(rd_ready), 0);
    cyc();
    check("hz3_rd_ready", 32'(rd_ready), 1);
    check("hz3_rd_en0", 32'(rd_en0), 1);
    check("hz3_rd_addr", 32'(rd_addr), 7);
    check("hz3_rd_thread", 32'(rd_thread_num), 2);
    cyc(); idle();
    check("hz4_rd_en1", 32'(rd_en1), 1);
    check("hz4_rd_valid", 32'(rd_valid), 0);
    cyc();
    check("hz5_rd_valid", 32'(rd_valid), 1);
    check("hz5_dout", 32'(dout), 'hBEEF);
    cyc();
    check("hz6_rd_valid", 32'(rd_valid), 0);

    // Back-to-back reads
    for (int i = 0; i < 4; i++) begin
      cyc(); drive(1'b0, 16'h0, 4'd0, 3'd0, 3'b000, 1'b1, 4'(i), 3'd0);
      check("b2b_rd_en0", 32'(rd_en0), 1);
      check("b2b_rd_valid", 32'(rd_valid), (i >= 2) ? 1 : 0);
    end
    for (int j = 0; j < 3; j++) begin
      cyc(); idle();
      check("b2b_tail_rd_valid", 32'(rd_valid), (j < 2) ? 1 : 0);
    end

    // Reset with two queued loads and a read in flight
    cyc(); drive(1'b1, 16'hE001, 4'd8, 3'd1, 3'b111, 1'b0, 4'd0, 3'd0);
    check("mr0_eu_ready", 32'(eu_ready), 'b001);
    cyc(); drive(1'b1, 16'hE002, 4'd10, 3'd1, 3'b111, 1'b1, 4'd9, 3'd5);
    check("mr1_eu_ready", 32'(eu_ready), 'b010);
    check("mr1_rd_ready", 32'(rd_ready), 1);
    cyc(); rst_n = 1'b0; drive(1'b1, 16'hE003, 4'd11, 3'd1, 3'b111, 1'b1, 4'd9, 3'd5);
    check("mr2_wr_en", 32'(wr_en), 0);
    check("mr2_mem_wr_en", 32'(mem_wr_en), 0);
    check("mr2_eu_ready", 32'(eu_ready), 0);
    check("mr2_rd_ready", 32'(rd_ready), 0);
    check("mr2_rd_en1", 32'(rd_en1), 1);
    cyc();
    check("mr3_rd_valid", 32'(rd_valid), 0);
    check("mr3_rd_en1", 32'(rd_en1), 0);
    cyc(); rst_n = 1'b1; idle();
    check("mr4_rd_valid", 32'(rd_valid), 0);
    check("mr4_fifo_empty", 32'(mem_wr_en), 0);
    check("mr4_almost_full", 32'(mem_almost_full), 0);
    check("mr4_overflow", 32'(mem_overflow), 0);

    // Overflow on the instance without high-water override
    cyc(); drive(1'b1, 16'hC001, 4'd1, 3'd0, 3'b111, 1'b0, 4'd0, 3'd0);
    check("ov1_eu_ready", 32'(b_eu_ready), 'b001);
    cyc(); drive(1'b1, 16'hC002, 4'd2, 3'd0, 3'b111, 1'b0, 4'd0, 3'd0);
    check("ov2_eu_ready", 32'(b_eu_ready), 'b010);
    cyc(); drive(1'b1, 16'hC003, 4'd3, 3'd0, 3'b111, 1'b0, 4'd0, 3'd0);
    check("ov3_eu_ready", 32'(b_eu_ready), 'b100);
    cyc(); drive(1'b1, 16'hC004, 4'd4, 3'd0, 3'b111, 1'b0, 4'd0, 3'd0);
    check("ov4_mem_wr_en", 32'(b_mem_wr_en), 1);
    check("ov4_mem_din", 32'(b_mem_din), 'hC001);
    cyc(); drive(1'b1, 16'hC005, 4'd5, 3'd0, 3'b111, 1'b0, 4'd0, 3'd0);
    check("ov5_eu_ready", 32'(b_eu_ready), 'b001);
    check("ov5_almost_full", 32'(b_mem_almost_full), 1);
    cyc(); drive(1'b1, 16'hC006, 4'd6, 3'd0, 3'b111, 1'b0, 4'd0, 3'd0);
    check("ov6_eu_ready", 32'(b_eu_ready), 'b010);
    check("ov6_overflow", 32'(b_mem_overflow), 0);
    cyc(); drive(1'b1, 16'hC007, 4'd7, 3'd0, 3'b111, 1'b0, 4'd0, 3'd0);
    check("ov7_eu_ready", 32'(b_eu_ready), 'b100);
    check("ov7_overflow", 32'(b_mem_overflow), 1);
    cyc(); drive(1'b1, 16'hC008, 4'd8, 3'd0, 3'b111, 1'b0, 4'd0, 3'd0);
    check("ov8_mem_wr_en", 32'(b_mem_wr_en), 1);
    check("ov8_mem_din", 32'(b_mem_din), 'hC002);
    for (int i = 0; i < 4; i++) begin
      cyc(); idle();
      check("ov_drain_mem_wr_en", 32'(b_mem_wr_en), 1);
      check("ov_drain_mem_din", 32'(b_mem_din), 32'(drain_exp[i]));
    end
    cyc();
    check("ov_end_mem_wr_en", 32'(b_mem_wr_en), 0);
    check("ov_end_overflow", 32'(b_mem_overflow), 1);
    check("ov_end_almost_full", 32'(b_mem_almost_full), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
